// File: rtl/debounce_scan_ctrl_if.sv
// Signal bundle between the button-debounce controller and its consumer:
// raw button levels in, tick strobe, scan status and debounced levels/events out.
interface debounce_scan_ctrl_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] level;
  logic            m_tick;
  logic [N_CH-1:0] curr_level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            scan_busy;

  modport master (
    input  level,
    output m_tick, curr_level, rise, fall, scan_busy
  );

  modport slave (
    output level,
    input  m_tick, curr_level, rise, fall, scan_busy
  );
endinterface

// File: rtl/debounce_scan_ctrl.sv
// Debounced push-button bank: one compare/count slot time-shared round-robin
// across channels after every sample tick; stable level plus rise/fall pulses.
module debounce_scan_ctrl #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 10,
  parameter int STABLE_TICKS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  debounce_scan_ctrl_if.master bus
);
  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("debounce_scan_ctrl: N_CH must be in 1..16");
  end
  // A tick must never land inside a scan, otherwise the snapshot would shift mid-scan.
  if (TICK_DIV < N_CH + 2) begin : g_bad_tick_div
    $error("debounce_scan_ctrl: TICK_DIV must be >= N_CH+2");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("debounce_scan_ctrl: STABLE_TICKS must be >= 1");
  end

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_e;

  logic [N_CH-1:0]  sync1_q, sync2_q, snap_q;
  logic [N_CH-1:0]  curr_q, curr_d, rise_q, rise_d, fall_q, fall_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             m_tick_q, busy_q;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  always_comb begin
    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    curr_d  = curr_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (m_tick_q) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (snap_q[idx_q] == curr_q[idx_q]) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] == CNT_LAST) begin
          curr_d[idx_q] = snap_q[idx_q];
          cnt_d[idx_q]  = '0;
          rise_d[idx_q] = snap_q[idx_q];
          fall_d[idx_q] = ~snap_q[idx_q];
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      snap_q   <= '0;
      presc_q  <= '0;
      m_tick_q <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= S_IDLE;
      idx_q    <= '0;
      curr_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= bus.level;
      sync2_q  <= sync1_q;
      presc_q  <= presc_d;
      m_tick_q <= (presc_d == PRE_LAST);
      if (m_tick_q) snap_q <= sync2_q;
      busy_q   <= (state_d == S_SCAN);
      state_q  <= state_d;
      idx_q    <= idx_d;
      curr_q   <= curr_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.m_tick     = m_tick_q;
  assign bus.scan_busy  = busy_q;
  assign bus.curr_level = curr_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed scenarios plus random bouncing inputs,
// all compared cycle by cycle against a tick-level reference model.
module tb_debounce_scan_ctrl;
  localparam int N_CH         = 4;
  localparam int TICK_DIV     = 10;
  localparam int STABLE_TICKS = 3;
  localparam int VW           = 3 * N_CH + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  debounce_scan_ctrl_if #(.N_CH(N_CH)) bus ();

  debounce_scan_ctrl #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: n counts cycles since the first cycle with reset low.
  int              n       = 0;
  logic            prev_rst = 1'b1;
  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] m_lvl, exp_rise, exp_fall;
  logic            exp_tick, exp_busy;
  int              m_cnt[N_CH];
  int              chg_at[N_CH];

  function automatic logic [VW-1:0] obs_vec();
    return {bus.m_tick, bus.scan_busy, bus.curr_level, bus.rise, bus.fall};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_tick, exp_busy, m_lvl, exp_rise, exp_fall};
  endfunction

  // One clock: drive inputs just after the edge, advance the model, park on the falling edge.
  task automatic step(input logic rst, input logic [N_CH-1:0] lv);
    logic [N_CH-1:0] snap;
    @(posedge clk);
    #1;
    reset     = rst;
    bus.level = lv;
    if (prev_rst) begin
      n = 0;
      hist.delete();
      m_lvl = '0;
      for (int i = 0; i < N_CH; i++) begin
        m_cnt[i]  = 0;
        chg_at[i] = -1;
      end
    end else begin
      n++;
    end
    prev_rst = rst;
    hist.push_back(lv);
    exp_rise = '0;
    exp_fall = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (chg_at[i] == n) begin
        m_lvl[i] = ~m_lvl[i];
        if (m_lvl[i]) exp_rise[i] = 1'b1;
        else          exp_fall[i] = 1'b1;
        chg_at[i] = -1;
      end
    end
    exp_tick = ((n % TICK_DIV) == TICK_DIV - 1);
    exp_busy = (n >= TICK_DIV) && ((n % TICK_DIV) < N_CH);
    if (exp_tick) begin
      snap = (n >= 2) ? hist[n-2] : '0;
      for (int i = 0; i < N_CH; i++) begin
        if (snap[i] != m_lvl[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == STABLE_TICKS) begin
            m_cnt[i]  = 0;
            chg_at[i] = n + 2 + i;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] tick_v;
    logic [19:0] busy_v;
    tick_v = '0;
    busy_v = '0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'hF);
      n_checks++;
      if (obs_vec() !== {VW{1'b0}}) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h expected 0", c, obs_vec());
      end
    end
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 4'hF);
      tick_v[n] = bus.m_tick;
      if (n < 20) busy_v[n] = bus.scan_busy;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_run cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (tick_v !== 32'h2008_0200) begin
      n_fail++;
      $display("FAIL reset_tick_times: got %h expected %h", tick_v, 32'h2008_0200);
    end
    n_checks++;
    if (busy_v !== 20'h03C00) begin
      n_fail++;
      $display("FAIL reset_busy_window: got %h expected %h", busy_v, 20'h03C00);
    end
  endtask

  task automatic test_clean_press();
    int rise_at, n_pulses;
    rise_at  = -1;
    n_pulses = 0;
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 4'b0001);
      if (bus.rise[0] && rise_at < 0) rise_at = n;
      n_pulses += $countones(bus.rise) + $countones(bus.fall);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (rise_at !== 31 || n_pulses !== 1) begin
      n_fail++;
      $display("FAIL clean_press_rise: got cycle %0d pulses %0d expected cycle 31 pulses 1", rise_at, n_pulses);
    end
  endtask

  task automatic test_bounce();
    int rise_at;
    logic [N_CH-1:0] lv;
    rise_at = -1;
    step(1'b1, 4'h0);
    for (int c = 0; c < 70; c++) begin
      lv    = '0;
      lv[1] = ((c >= 5) && (c <= 25)) || (c >= 31);
      step(1'b0, lv);
      if (bus.rise[1] && rise_at < 0) rise_at = n;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (rise_at !== 62) begin
      n_fail++;
      $display("FAIL bounce_rise: got cycle %0d expected 62", rise_at);
    end
  endtask

  task automatic test_simultaneous();
    int r2_at, r3_at, r2_n, r3_n;
    logic [N_CH-1:0] lvl34;
    r2_at = -1; r3_at = -1; r2_n = 0; r3_n = 0;
    lvl34 = '0;
    step(1'b1, 4'h0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 4'b1100);
      if (bus.rise[2]) begin r2_n++; r2_at = n; end
      if (bus.rise[3]) begin r3_n++; r3_at = n; end
      if (n == 34) lvl34 = bus.curr_level;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL simultaneous cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (r2_at !== 33 || r3_at !== 34 || r2_n !== 1 || r3_n !== 1 || lvl34 !== 4'b1100) begin
      n_fail++;
      $display("FAIL simultaneous_order: got r2@%0d x%0d r3@%0d x%0d lvl %b expected r2@33 x1 r3@34 x1 lvl 1100",
               r2_at, r2_n, r3_at, r3_n, lvl34);
    end
  endtask

  task automatic test_release();
    int fall_at, fall_n;
    fall_at = -1;
    fall_n  = 0;
    step(1'b1, 4'h0);
    for (int c = 0; c < 80; c++) begin
      step(1'b0, (c < 40) ? 4'b0001 : 4'b0000);
      if (bus.fall[0]) begin fall_n++; fall_at = n; end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL release cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (fall_at !== 71 || fall_n !== 1) begin
      n_fail++;
      $display("FAIL release_fall: got cycle %0d x%0d expected cycle 71 x1", fall_at, fall_n);
    end
  endtask

  task automatic test_reset_mid_scan();
    int rise_at, rise_n, tick_at;
    logic busy_at_rst;
    rise_at = -1; rise_n = 0; tick_at = -1;
    step(1'b1, 4'h0);
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 4'b0001);
      rise_n += $countones(bus.rise);
    end
    step(1'b1, 4'b0001);
    busy_at_rst = bus.scan_busy;
    n_checks++;
    if (busy_at_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_busy: got %b expected 1", busy_at_rst);
    end
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 4'b0001);
      if (bus.m_tick && tick_at < 0) tick_at = n;
      if (bus.rise[0] && rise_at < 0) rise_at = n;
      rise_n += $countones(bus.rise);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midscan cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (tick_at !== 9 || rise_at !== 31 || rise_n !== 1) begin
      n_fail++;
      $display("FAIL midscan_restart: got tick@%0d rise@%0d x%0d expected tick@9 rise@31 x1",
               tick_at, rise_at, rise_n);
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] lv;
    logic            rst;
    int              hold[N_CH];
    int              events;
    lv     = '0;
    events = 0;
    for (int i = 0; i < N_CH; i++) hold[i] = 0;
    step(1'b1, lv);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (hold[i] == 0) begin
          lv[i]   = ~lv[i];
          hold[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 60);
        end else begin
          hold[i]--;
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      step(rst, lv);
      events += $countones(bus.rise) + $countones(bus.fall);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (events < 4) begin
      n_fail++;
      $display("FAIL random_activity: got %0d events expected at least 4", events);
    end
  endtask

  initial begin
    bus.level = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
- Controller for a bank of debounced push-button inputs.
- Generates the periodic sample strobe `m_tick` internally and holds a snapshot of all inputs at each tick.
- Time-shares one compare/count evaluation slot across N_CH channels, round-robin, one channel per clock.
- Outputs the stable level per channel plus one-cycle rise/fall event pulses. Sits between raw board inputs and the FSM logic that consumes button events.

Parameters:
- N_CH, 4: number of input channels; must be 1..16.
- TICK_DIV, 10: clocks per `m_tick` period; must be >= N_CH+2.
- STABLE_TICKS, 3: consecutive differing ticks required before `curr_level` changes; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- level  input  N_CH  raw, asynchronous, bouncy inputs.
- m_tick  output  1  one-cycle sample strobe, every TICK_DIV clocks.
- curr_level  output  N_CH  debounced stable level per channel.
- rise  output  N_CH  one-cycle pulse when `curr_level[i]` goes 0->1.
- fall  output  N_CH  one-cycle pulse when `curr_level[i]` goes 1->0.
- scan_busy  output  1  high while the scan FSM is in SCAN.

Behaviour:
- Reset state: all of the following are 0 — prescaler, `m_tick`, `curr_level`, `rise`, `fall`, `scan_busy`, synchroniser flops, snapshot register, per-channel counters. Scan index is 0 and the FSM is in IDLE.
- Reset mid-scan aborts the scan immediately. Accumulated counts are lost.
- Synchroniser: each `level` bit passes through 2 flops. The synchronised value is `lvl_s`.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `m_tick` is registered and is high in the cycle the prescaler equals TICK_DIV-1.
  - The first `m_tick` is in cycle TICK_DIV-1, counting the first cycle with reset low as cycle 0.
- Snapshot: in the cycle `m_tick` is high, the snapshot register loads `lvl_s`. All channels of that scan are evaluated against this single snapshot.
- Scan FSM has two states, IDLE and SCAN:
  - IDLE -> SCAN on the clock edge ending the `m_tick` cycle, with idx=0.
  - In SCAN, each cycle evaluates channel idx, then idx++.
  - After evaluating idx = N_CH-1, return to IDLE and reset idx to 0.
  - `scan_busy` is 1 exactly while in SCAN, i.e. N_CH cycles per tick.
- Per-channel evaluation of channel i, in its SCAN cycle:
  - If snap[i] == curr_level[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_TICKS-1: curr_level[i] <= snap[i] and cnt[i] <= 0. Pulse `rise[i]` if snap[i]=1, else `fall[i]`.
  - Else: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(STABLE_TICKS) bits, minimum 1.
- Timing: for `m_tick` at cycle T, channel i is evaluated in cycle T+1+i. Its `curr_level`/`rise`/`fall` update is visible in cycle T+2+i. A `rise`/`fall` pulse lasts exactly 1 cycle and coincides with the first cycle of the new `curr_level`.
- Bounce handling: any single tick where snap[i] matches `curr_level[i]` clears cnt[i], so only STABLE_TICKS *consecutive* differing ticks cause a change.
- STABLE_TICKS=1: `curr_level` follows snap on the first differing tick.
- Channels are independent. Simultaneous changes on several channels produce pulses in consecutive cycles in index order; pulses on different channels are never merged.
- Because TICK_DIV >= N_CH+2, a tick never arrives during SCAN. Parameter values violating this are illegal, and RTL asserts this at elaboration.
- Input latency: a level change reaches `lvl_s` 2 cycles later. It is sampled at the next `m_tick`; a change arriving in the tick cycle itself misses that tick.

Test Plan:
All scenarios use N_CH=4, TICK_DIV=10, STABLE_TICKS=3.
1. Reset: hold reset 3 cycles with level=4'hF, then release.
   - All outputs 0 during reset.
   - `m_tick` first high at cycle 9 after release, then at cycles 19, 29, ….
   - `scan_busy` high in cycles 10-13.
2. Clean press: level[0]=1 from cycle 0 after reset.
   - Snap[0]=1 at ticks 9, 19, 29.
   - `curr_level[0]`=1 from cycle 31, with `rise[0]`=1 only in cycle 31.
   - No pulses on other channels.
3. Bounce reject:
   - level[1] high for cycles 5-25, low 26-30, high from 31.
   - The low at tick 29 clears the count, so no change by tick 39.
   - `rise[1]` occurs at cycle 62 (ticks 39, 49, 59; channel 1 offset).
4. Simultaneous events:
   - level[2] and level[3] both rise at cycle 0.
   - `rise[2]` in cycle 33 and `rise[3]` in cycle 34, each exactly 1 cycle wide.
   - `curr_level`=4'b1100 from cycle 34.
5. Release: with `curr_level[0]`=1, drive level[0]=0 held steady.
   - `fall[0]` fires exactly 1 cycle, 2 cycles after the 3rd tick that snaps 0.
   - `curr_level[0]`=0 from that same cycle.
6. Reset mid-scan:
   - ch0 has cnt=2, i.e. after 2 differing ticks.
   - Assert reset for 1 cycle during `scan_busy`.
   - All counters are 0 and `m_tick` restarts at cycle 9 after release.
   - ch0 needs 3 further ticks before `rise[0]`; no pulse occurs on the aborted scan.
